// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: segment table, bit order, digit limits.
// Latency: n/a (package). Backpressure: n/a.
// Segment vectors are {a,b,c,d,e,f,g}, active-high.
package hex_display_pkg;

  localparam int MIN_DIGITS = 1;
  localparam int MAX_DIGITS = 8;
  localparam int SEG_W      = 7;

  // Bit position of each segment within a segment vector.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Hex nibble to 7-segment pattern decoder.
// Latency: combinational. Backpressure: none.
// Output order {a,b,c,d,e,f,g}.
module hex7seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  logic [SEG_W-1:0] raw;

  assign raw = HEX_SEG_TABLE[nibble];
  assign seg = {raw[SEG_A], raw[SEG_B], raw[SEG_C], raw[SEG_D],
                raw[SEG_E], raw[SEG_F], raw[SEG_G]};

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display scanner with leading-zero blanking; PWM dimming under HEX_DISPLAY_MUX_DIM_EN.
// Latency: all outputs registered, one cycle behind counter/shadow state.
// Backpressure: none; free-running scan, inputs sampled once per frame.
module hex_display_mux
  import hex_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SLOT_CYCLES = 128,
  parameter int BRIGHT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic                blank_lz,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [DIGITS-1:0]   anodes,
  output logic [SEG_W-1:0]    segments,
  output logic                dp_out,
  output logic                frame_start
);

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  if (DIGITS < MIN_DIGITS || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("hex_display_mux: DIGITS out of range");
  end

  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blank_lz;
  logic [BRIGHT_W-1:0] sh_bright;

  logic                frame_edge;
  logic                pwm_on;
  logic                digit_on;
  logic                run;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_nibble;
  logic [SEG_W-1:0]    cur_seg;
  logic [DIGITS-1:0]   anodes_nxt;
  logic [SEG_W-1:0]    segments_nxt;
  logic                dp_nxt;

  assign frame_edge = (slot_cnt == '0) && (digit_idx == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      sh_data     <= '0;
      sh_dp       <= '0;
      sh_blank_lz <= 1'b0;
      sh_bright   <= '0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_edge) begin
        sh_data     <= data;
        sh_dp       <= dp;
        sh_blank_lz <= blank_lz;
        sh_bright   <= brightness;
      end
    end
  end

  // Suppression run walks down from the top digit; a non-zero nibble or a dp ends it.
  always_comb begin
    blank_vec = '0;
    run       = sh_blank_lz;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run          = run && (sh_data[4*i +: 4] == 4'h0) && !sh_dp[i];
      blank_vec[i] = run;
    end
  end

`ifdef HEX_DISPLAY_MUX_DIM_EN
  assign pwm_on = (slot_cnt[SLOT_W-1 -: BRIGHT_W] <= sh_bright);
`else
  logic unused_bright;
  assign unused_bright = ^sh_bright;
  assign pwm_on        = 1'b1;
`endif

  assign cur_nibble = sh_data[{digit_idx, 2'b00} +: 4];

  hex7seg_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // slot_cnt==0 is the dead-time cycle between digits.
  assign digit_on = (slot_cnt != '0) && pwm_on && !blank_vec[digit_idx];

  always_comb begin
    anodes_nxt   = '0;
    segments_nxt = '0;
    dp_nxt       = 1'b0;
    if (digit_on) begin
      anodes_nxt   = DIGITS'(1) << digit_idx;
      segments_nxt = cur_seg;
      dp_nxt       = sh_dp[digit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anodes      <= '0;
      segments    <= '0;
      dp_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      anodes      <= anodes_nxt;
      segments    <= segments_nxt;
      dp_out      <= dp_nxt;
      frame_start <= frame_edge;
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Scoreboard bench for hex_display_mux: 4 digits at 8 and 32 cycles per slot.
// Optional dimming expectations follow HEX_DISPLAY_MUX_DIM_EN.
module tb_hex_display_mux;

  localparam int DIGITS = 4;
  localparam int SLOT8  = 8;
  localparam int SLOT32 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [2:0]  bright8;
  logic [3:0]  bright32;
  logic [3:0]  an8, an32;
  logic [6:0]  seg8, seg32;
  logic        dpo8, dpo32, fs8, fs32;
  logic        sel32;

  wire [3:0] obs_an  = sel32 ? an32  : an8;
  wire [6:0] obs_seg = sel32 ? seg32 : seg8;
  wire       obs_dp  = sel32 ? dpo32 : dpo8;
  wire       obs_fs  = sel32 ? fs32  : fs8;

  hex_display_mux #(.DIGITS(DIGITS), .SLOT_CYCLES(SLOT8), .BRIGHT_W(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank_lz(blank_lz),
    .brightness(bright8), .anodes(an8), .segments(seg8), .dp_out(dpo8), .frame_start(fs8)
  );

  hex_display_mux #(.DIGITS(DIGITS), .SLOT_CYCLES(SLOT32), .BRIGHT_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank_lz(blank_lz),
    .brightness(bright32), .anodes(an32), .segments(seg32), .dp_out(dpo32), .frame_start(fs32)
  );

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    int         on_cnt;
  } exp_t;

  exp_t sb[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: ref_seg = 7'b1111110;  4'h1: ref_seg = 7'b0110000;
      4'h2: ref_seg = 7'b1101101;  4'h3: ref_seg = 7'b1111001;
      4'h4: ref_seg = 7'b0110011;  4'h5: ref_seg = 7'b1011011;
      4'h6: ref_seg = 7'b1011111;  4'h7: ref_seg = 7'b1110000;
      4'h8: ref_seg = 7'b1111111;  4'h9: ref_seg = 7'b1111011;
      4'hA: ref_seg = 7'b1110111;  4'hB: ref_seg = 7'b0011111;
      4'hC: ref_seg = 7'b1001110;  4'hD: ref_seg = 7'b0111101;
      4'hE: ref_seg = 7'b1001111;  default: ref_seg = 7'b1000111;
    endcase
  endfunction

  // Expected per-digit result for one frame; digits above the highest
  // non-zero/dp digit are dark when blanking is on.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input bit blz, input int on_cnt);
    int top = 0;
    for (int i = 0; i < DIGITS; i++)
      if (d[4*i +: 4] != 4'h0 || p[i]) top = i;
    for (int i = 0; i < DIGITS; i++) begin
      exp_t e;
      e.seg    = ref_seg(d[4*i +: 4]);
      e.dp     = p[i];
      e.on_cnt = (blz && i > top) ? 0 : on_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (obs_fs !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_cnt++;
    if (obs_fs !== 1'b1) $display("FAIL %s frame_start timeout: got %b want 1", tag, obs_fs);
    else pass_cnt++;
  endtask

  // Consumes one frame starting at a frame_start sample; optionally changes data mid-frame.
  task automatic observe_frame(input string tag, input bit fresh, input int change_at, input logic [15:0] new_data);
    int slot = sel32 ? SLOT32 : SLOT8;
    if (fresh) @(negedge clk);
    wait_frame(tag);
    for (int d = 0; d < DIGITS; d++) begin
      exp_t e;
      int on_cnt = 0, first = -1, last = -1;
      bit stray = 0, seg_bad = 0, dp_bad = 0, fs_bad = 0;
      logic [6:0] seg_seen = '0;
      logic [3:0] onehot = 4'b0001 << d;
      e = sb.pop_front();
      for (int k = 0; k < slot; k++) begin
        if (d*slot + k == change_at) data = new_data;
        if (obs_an === onehot) begin
          on_cnt++;
          if (first < 0) first = k;
          last = k;
          if (obs_seg !== e.seg) begin seg_bad = 1; seg_seen = obs_seg; end
          if (obs_dp !== e.dp) dp_bad = 1;
        end else if (obs_an !== 4'b0 || obs_seg !== 7'b0 || obs_dp !== 1'b0) begin
          stray = 1;
        end
        if (d*slot + k != 0 && obs_fs !== 1'b0) fs_bad = 1;
        @(negedge clk);
      end
      check_cnt++;
      if (on_cnt != e.on_cnt) $display("FAIL %s d%0d on_count: got %0d want %0d", tag, d, on_cnt, e.on_cnt);
      else pass_cnt++;
      check_cnt++;
      if (first != (e.on_cnt > 0 ? 1 : -1) || last != (e.on_cnt > 0 ? e.on_cnt : -1))
        $display("FAIL %s d%0d on_window: got %0d..%0d want 1..%0d", tag, d, first, last, e.on_cnt);
      else pass_cnt++;
      check_cnt++;
      if (stray) $display("FAIL %s d%0d stray_output: got stray=1 want 0", tag, d);
      else pass_cnt++;
      check_cnt++;
      if (fs_bad) $display("FAIL %s d%0d frame_start_extra: got extra pulse want none", tag, d);
      else pass_cnt++;
      if (e.on_cnt > 0) begin
        check_cnt++;
        if (seg_bad) $display("FAIL %s d%0d segments: got %b want %b", tag, d, seg_seen, e.seg);
        else pass_cnt++;
        check_cnt++;
        if (dp_bad) $display("FAIL %s d%0d dp_out: got %b want %b", tag, d, !e.dp, e.dp);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (obs_fs !== 1'b1) $display("FAIL %s frame_period: got frame_start=%b want 1", tag, obs_fs);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = 16'hCAFE; dp = 4'b0; blank_lz = 1'b0;
    bright8 = 3'd7; bright32 = 4'd15; sel32 = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({an8, seg8, dpo8, fs8} !== 13'b0) $display("FAIL reset_dut8: got %b want 0", {an8, seg8, dpo8, fs8});
    else pass_cnt++;
    check_cnt++;
    if ({an32, seg32, dpo32, fs32} !== 13'b0) $display("FAIL reset_dut32: got %b want 0", {an32, seg32, dpo32, fs32});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (fs8 !== 1'b1 || an8 !== 4'b0) $display("FAIL reset_release: got fs=%b an=%b want fs=1 an=0000", fs8, an8);
    else pass_cnt++;
  endtask

  task automatic test_cafe();
    data = 16'hCAFE; dp = 4'b0; blank_lz = 1'b0; bright8 = 3'd7;
    push_frame(16'hCAFE, 4'b0, 1'b0, SLOT8 - 1);
    observe_frame("cafe", 1'b1, -1, 16'h0);
  endtask

  task automatic test_back_to_back();
    data = 16'h9D0B; dp = 4'b1001;
    push_frame(16'h9D0B, 4'b1001, 1'b0, SLOT8 - 1);
    observe_frame("b2b_a", 1'b1, -1, 16'h0);
    push_frame(16'h9D0B, 4'b1001, 1'b0, SLOT8 - 1);
    observe_frame("b2b_b", 1'b0, -1, 16'h0);
  endtask

  task automatic test_leading_zero();
    data = 16'h0042; dp = 4'b0000; blank_lz = 1'b1;
    push_frame(16'h0042, 4'b0000, 1'b1, SLOT8 - 1);
    observe_frame("lz", 1'b1, -1, 16'h0);
    dp = 4'b0100;
    push_frame(16'h0042, 4'b0100, 1'b1, SLOT8 - 1);
    observe_frame("lz_dp", 1'b1, -1, 16'h0);
    data = 16'h0000; dp = 4'b0000;
    push_frame(16'h0000, 4'b0000, 1'b1, SLOT8 - 1);
    observe_frame("all_zero", 1'b1, -1, 16'h0);
  endtask

  task automatic test_mid_frame();
    data = 16'h1234; dp = 4'b0; blank_lz = 1'b0;
    push_frame(16'h1234, 4'b0, 1'b0, SLOT8 - 1);
    observe_frame("mid_old", 1'b1, 10, 16'h5678);
    push_frame(16'h5678, 4'b0, 1'b0, SLOT8 - 1);
    observe_frame("mid_new", 1'b0, -1, 16'h0);
  endtask

  task automatic test_dim();
    int dim_on;
`ifdef HEX_DISPLAY_MUX_DIM_EN
    dim_on = 3;
`else
    dim_on = SLOT32 - 1;
`endif
    sel32 = 1'b1; data = 16'hCAFE; dp = 4'b0010; blank_lz = 1'b0; bright32 = 4'd1;
    push_frame(16'hCAFE, 4'b0010, 1'b0, dim_on);
    observe_frame("dim1", 1'b1, -1, 16'h0);
    bright32 = 4'd15;
    push_frame(16'hCAFE, 4'b0010, 1'b0, SLOT32 - 1);
    observe_frame("dim15", 1'b1, -1, 16'h0);
    sel32 = 1'b0;
  endtask

  task automatic test_reset_mid();
    data = 16'h1234; dp = 4'b0; blank_lz = 1'b0;
    @(negedge clk);
    wait_frame("rst_mid");
    repeat (2*SLOT8 + 3) @(negedge clk);
    check_cnt++;
    if (an8 !== 4'b0100) $display("FAIL rst_mid_pre: got an=%b want 0100", an8);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({an8, seg8, dpo8, fs8} !== 13'b0) $display("FAIL rst_mid_clear: got %b want 0", {an8, seg8, dpo8, fs8});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (fs8 !== 1'b1 || an8 !== 4'b0) $display("FAIL rst_mid_restart: got fs=%b an=%b want fs=1 an=0000", fs8, an8);
    else pass_cnt++;
    push_frame(16'h1234, 4'b0, 1'b0, SLOT8 - 1);
    observe_frame("rst_mid_frame", 1'b0, -1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_cafe();
    test_back_to_back();
    test_leading_zero();
    test_mid_frame();
    test_dim();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hex_display_mux.md
HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SLOT_CYCLES, default 128, clk cycles per digit slot (power of two, >= 2**BRIGHT_W).
REQ-003 SHALL have parameter BRIGHT_W, default 4, brightness control width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port data  input  4*DIGITS  hex nibbles; data[3:0] is digit 0 (rightmost).
REQ-007 SHALL have port dp  input  DIGITS  decimal-point request per digit.
REQ-008 SHALL have port blank_lz  input  1  leading-zero suppression enable.
REQ-009 SHALL have port brightness  input  BRIGHT_W  on-time level, 0 = dimmest non-zero, all-ones = full.
REQ-010 SHALL have port anodes  output  DIGITS  one-hot digit enable, active-high; bit i drives digit i.
REQ-011 SHALL have port segments  output  7  {a,b,c,d,e,f,g}, active-high.
REQ-012 SHALL have port dp_out  output  1  decimal-point segment, active-high.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL count slot_cnt 0..SLOT_CYCLES-1, then wrap to 0 and advance digit_idx 0..DIGITS-1, wrapping DIGITS-1 -> 0.
REQ-015 SHALL, when slot_cnt==0 and digit_idx==0, capture data, dp, blank_lz, brightness into shadow registers and assert frame_start that cycle; mid-frame input changes SHALL not affect display until the next frame.
REQ-016 SHALL register all outputs; outputs reflect counter/shadow state with exactly one cycle latency.
REQ-017 SHALL force anodes to 0 at slot_cnt==0 of every slot (one-cycle dead time against ghosting).
REQ-018 SHALL assert anodes[digit_idx] only when slot_cnt!=0 and slot_cnt[MSB-side BRIGHT_W bits] <= shadow brightness; otherwise anodes==0.
REQ-019 SHALL drive segments with the standard hex decode of the current shadow nibble (0..9, A,b,C,d,E,F) and dp_out with shadow dp[digit_idx], whenever anodes is non-zero; segments and dp_out SHALL be 0 whenever anodes==0.
REQ-020 SHALL, with shadow blank_lz=1, blank (anodes bit held 0) every digit above the most significant non-zero nibble; digit 0 SHALL never be blanked; a digit with dp set SHALL not be blanked and SHALL end the suppression run.
REQ-021 SHALL treat all-zero data with blank_lz=1 as showing only digit 0 as "0".

Reset
REQ-022 SHALL, while rst_n==0 at a clk edge, clear slot_cnt, digit_idx, all shadow registers, anodes, segments, dp_out, frame_start to 0.
REQ-023 SHALL restart at slot 0/digit 0 on the first cycle after rst_n rises, with frame_start asserted one cycle later; reset mid-frame SHALL abandon the frame without any partial anode pulse.

Configuration
REQ-024 SHALL, with macro HEX_DISPLAY_MUX_DIM_EN defined, implement brightness PWM per REQ-018.
REQ-025 SHALL, without HEX_DISPLAY_MUX_DIM_EN, ignore brightness and keep the digit on for slot_cnt 1..SLOT_CYCLES-1; port brightness SHALL still exist.

Structure
REQ-026 SHALL place the 16-entry nibble-to-segment table, segment bit-order constants, and digit-count limits in shared package hex_display_pkg.
REQ-027 SHALL instantiate one combinational sub-module hex7seg_decode (nibble in, 7 segments out); counters, shadow, and blanking logic stay in hex_display_mux.

Verification
REQ-028 SHALL test DIGITS=4, SLOT_CYCLES=8, data=16'hCAFE, dp=0, blank_lz=0, full brightness -> digits 0..3 show 7'b1001111, 7'b1000111, 7'b1110111, 7'b1001110, each on 7 of 8 cycles, frame_start every 32 cycles.
REQ-029 SHALL test data=16'h0042, blank_lz=1 -> digits 3,2 never enabled; digit 1 = "4", digit 0 = "2"; with dp=4'b0100 digit 2 shows "0" with dp_out=1.
REQ-030 SHALL test data=0, blank_lz=1 -> only anodes[0] ever asserts, segments=7'b1111110.
REQ-031 SHALL test data changed from 16'h1234 to 16'h5678 mid-frame -> current frame completes with 1234; 5678 appears from the next frame_start.
REQ-032 SHALL test with HEX_DISPLAY_MUX_DIM_EN, SLOT_CYCLES=32, BRIGHT_W=4, brightness=1 -> digit on for slot_cnt 1..3 only; without macro -> on for 1..31.
REQ-033 SHALL test rst_n low for one cycle during digit 2 -> all outputs 0 next cycle, then scan restarts at digit 0 with frame_start.
